digit_load_seq: RTL and testbench

//  Command-entry sequencer that drives the clock datapath's load interface.

---
 rtl/digit_load_pkg.sv | 33 +++
 rtl/ascii_digit_check.sv | 19 +
 rtl/digit_load_seq.sv | 206 ++++++++++++++++++++
 tb/tb_digit_load_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/digit_load_pkg.sv
// Shared definitions for the digit-entry sequencer: FSM state encoding,
// ASCII constants and digit position indices.
package digit_load_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_GET0  = 4'd1,
    S_GET1  = 4'd2,
    S_GET2  = 4'd3,
    S_GET3  = 4'd4,
    S_EMIT0 = 4'd5,
    S_EMIT1 = 4'd6,
    S_EMIT2 = 4'd7,
    S_EMIT3 = 4'd8,
    S_ERR   = 4'd9
  } state_e;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_FIVE  = 8'h35;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  localparam logic [1:0] POS_MTENS = 2'd0;
  localparam logic [1:0] POS_MONES = 2'd1;
  localparam logic [1:0] POS_STENS = 2'd2;
  localparam logic [1:0] POS_SONES = 2'd3;

  // Tens positions only accept 0..5
  function automatic logic pos_is_tens(input logic [1:0] pos);
    return (pos == POS_MTENS) || (pos == POS_STENS);
  endfunction

endpackage

// File: rtl/ascii_digit_check.sv
// Combinational range check of one received ASCII character against the
// allowed digit range of a tens (0..5) or ones (0..9) position.
module ascii_digit_check
  import digit_load_pkg::*;
(
  input  logic [7:0] rx_data,
  input  logic       is_tens,
  output logic       is_valid,
  output logic [3:0] value
);

  logic [7:0] w_max;

  assign w_max    = is_tens ? ASCII_FIVE : ASCII_NINE;
  assign is_valid = (rx_data >= ASCII_ZERO) && (rx_data <= w_max);
  // '0'..'9' are 8'h30..8'h39, so the low nibble is already the digit value
  assign value    = rx_data[3:0];

endmodule

// File: rtl/digit_load_seq.sv
// Command-entry sequencer: collects 'T'/'A' + MMSS from a byte stream,
// validates the digits and replays them one per cycle on the load interface.
// Optional byte echo on a transmit port when DIGIT_LOAD_ECHO_EN is defined.
//
// state | meaning
// IDLE  | waiting for a command byte
// GETn  | collecting digit n (Mtens, Mones, Stens, Sones)
// EMITk | driving load strobe for position k, rx held off
// ERR   | one-cycle error pulse, then back to IDLE
module digit_load_seq
  import digit_load_pkg::*;
#(
  parameter logic [7:0]  CMD_TIME   = 8'h54,
  parameter logic [7:0]  CMD_ALARM  = 8'h41,
  parameter logic [7:0]  ABORT_CHAR = 8'h1B,
  parameter logic [23:0] TO_CYC     = 24'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
`ifdef DIGIT_LOAD_ECHO_EN
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
`endif
  output logic       ld_time,
  output logic       ld_alarm,
  output logic       ldMtens,
  output logic       ldMones,
  output logic       ldStens,
  output logic       ldSones,
  output logic [3:0] ld_num,
  output logic       run,
  output logic       busy,
  output logic       err
);

  state_e      r_state;
  state_e      w_next;
  state_e      w_get_next;
  logic        r_mode_t;
  logic [3:0]  r_digits [4];
  logic [23:0] r_to_cnt;
  logic        r_ld_time;
  logic        r_ld_alarm;
  logic [3:0]  r_sel;
  logic [3:0]  r_num;

  logic        w_get;
  logic        w_emit;
  logic        w_next_get;
  logic        w_accept;
  logic        w_is_cmd;
  logic        w_abort;
  logic        w_valid;
  logic [3:0]  w_value;
  logic [1:0]  w_pos;
  logic        w_timeout;

  assign w_get      = (r_state == S_GET0) || (r_state == S_GET1) ||
                      (r_state == S_GET2) || (r_state == S_GET3);
  assign w_emit     = (r_state == S_EMIT0) || (r_state == S_EMIT1) ||
                      (r_state == S_EMIT2) || (r_state == S_EMIT3);
  assign w_next_get = (w_next == S_GET0) || (w_next == S_GET1) ||
                      (w_next == S_GET2) || (w_next == S_GET3);
  assign w_accept   = rx_valid && rx_ready;
  assign w_is_cmd   = (rx_data == CMD_TIME) || (rx_data == CMD_ALARM);
  assign w_abort    = (rx_data == ABORT_CHAR);
  assign w_timeout  = w_get && !w_accept && (TO_CYC != 24'd0) && (r_to_cnt <= 24'd1);

  // Digit position being collected and the state that follows it
  always_comb begin
    w_pos      = POS_MTENS;
    w_get_next = S_GET1;
    case (r_state)
      S_GET1: begin w_pos = POS_MONES; w_get_next = S_GET2;  end
      S_GET2: begin w_pos = POS_STENS; w_get_next = S_GET3;  end
      S_GET3: begin w_pos = POS_SONES; w_get_next = S_EMIT0; end
      default: ;
    endcase
  end

  ascii_digit_check u_check (
    .rx_data  (rx_data),
    .is_tens  (pos_is_tens(w_pos)),
    .is_valid (w_valid),
    .value    (w_value)
  );

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_cmd) w_next = S_GET0;
      S_GET0, S_GET1, S_GET2, S_GET3: begin
        if (w_accept) begin
          if (w_abort)      w_next = S_IDLE;
          else if (w_valid) w_next = w_get_next;
          else              w_next = S_ERR;
        end else if (w_timeout) begin
          w_next = S_ERR;
        end
      end
      S_EMIT0: w_next = S_EMIT1;
      S_EMIT1: w_next = S_EMIT2;
      S_EMIT2: w_next = S_EMIT3;
      S_EMIT3: w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, mode, digit buffer and inactivity timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_mode_t <= 1'b0;
      r_to_cnt <= 24'd0;
      for (int i = 0; i < 4; i++) r_digits[i] <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_accept && w_is_cmd)
        r_mode_t <= (rx_data == CMD_TIME);
      if (w_get && w_accept && !w_abort && w_valid)
        r_digits[w_pos] <= w_value;
      // Load TO_CYC-1 so the timeout lands exactly TO_CYC cycles after the last byte
      if (w_accept && w_next_get)
        r_to_cnt <= (TO_CYC == 24'd0) ? 24'd0 : TO_CYC - 24'd1;
      else if (w_get && r_to_cnt != 24'd0)
        r_to_cnt <= r_to_cnt - 24'd1;
      else if (!w_get)
        r_to_cnt <= 24'd0;
    end
  end

  // Registered load strobes, computed from the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_time  <= 1'b0;
      r_ld_alarm <= 1'b0;
      r_sel      <= 4'b0000;
      r_num      <= 4'd0;
    end else begin
      r_ld_time  <= 1'b0;
      r_ld_alarm <= 1'b0;
      r_sel      <= 4'b0000;
      r_num      <= 4'd0;
      case (w_next)
        S_EMIT0: begin r_sel <= 4'b1000; r_num <= r_digits[0]; end
        S_EMIT1: begin r_sel <= 4'b0100; r_num <= r_digits[1]; end
        S_EMIT2: begin r_sel <= 4'b0010; r_num <= r_digits[2]; end
        S_EMIT3: begin r_sel <= 4'b0001; r_num <= r_digits[3]; end
        default: ;
      endcase
      if ((w_next == S_EMIT0) || (w_next == S_EMIT1) ||
          (w_next == S_EMIT2) || (w_next == S_EMIT3)) begin
        r_ld_time  <= r_mode_t;
        r_ld_alarm <= !r_mode_t;
      end
    end
  end

`ifdef DIGIT_LOAD_ECHO_EN
  logic [7:0] r_tx_data;
  logic       r_tx_valid;
  logic       w_reject;

  assign w_reject = w_get && (w_abort || !w_valid);

  // Echo each consumed byte; rejected/aborted entries and timeouts echo '?'
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
    end else if (w_accept) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= w_reject ? ASCII_QMARK : rx_data;
    end else if (w_timeout) begin
      r_tx_valid <= 1'b1;
      r_tx_data  <= ASCII_QMARK;
    end else if (tx_ready) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign rx_ready = !w_emit && !(r_tx_valid && !tx_ready);
`else
  assign rx_ready = !w_emit;
`endif

  assign ld_time  = r_ld_time;
  assign ld_alarm = r_ld_alarm;
  assign ldMtens  = r_sel[3];
  assign ldMones  = r_sel[2];
  assign ldStens  = r_sel[1];
  assign ldSones  = r_sel[0];
  assign ld_num   = r_num;
  assign run      = !(r_mode_t && (w_get || w_emit));
  assign busy     = (r_state != S_IDLE);
  assign err      = (r_state == S_ERR);

endmodule

// File: tb/tb_digit_load_seq.sv
// Scoreboard bench for digit_load_seq: stimulus pushes expected load/err
// events, a negedge monitor pops and compares whenever one appears.
module tb_digit_load_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic       ld_time, ld_alarm, ldMtens, ldMones, ldStens, ldSones;
  logic [3:0] ld_num;
  logic       run, busy, err;

  int total = 0;
  int bad   = 0;
  logic [10:0] exp_q[$];

  digit_load_seq #(.TO_CYC(24'd16)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .ld_time  (ld_time),
    .ld_alarm (ld_alarm),
    .ldMtens  (ldMtens),
    .ldMones  (ldMones),
    .ldStens  (ldStens),
    .ldSones  (ldSones),
    .ld_num   (ld_num),
    .run      (run),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] ev(input logic e, input logic t, input logic a,
                                     input logic [3:0] sel, input logic [3:0] num);
    return {e, t, a, sel, num};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_load(input logic t, input logic [3:0] d0, input logic [3:0] d1,
                           input logic [3:0] d2, input logic [3:0] d3);
    exp_q.push_back(ev(1'b0, t, !t, 4'b1000, d0));
    exp_q.push_back(ev(1'b0, t, !t, 4'b0100, d1));
    exp_q.push_back(ev(1'b0, t, !t, 4'b0010, d2));
    exp_q.push_back(ev(1'b0, t, !t, 4'b0001, d3));
  endtask

  // Present a byte at a negedge and hold it until consumed; returns cycles waited
  task automatic send_byte(input logic [7:0] b, output int waits);
    rx_data  = b;
    rx_valid = 1'b1;
    waits    = 0;
    while (!rx_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!rx_ready) chk("rx_ready_timeout", 0, 1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    int w;
    for (int i = 0; i < s.len(); i++) send_byte(s[i], w);
  endtask

  // Monitor: any strobe or err pulse must match the head of the scoreboard
  always @(negedge clk) begin : monitor
    logic [10:0] got;
    got = {err, ld_time, ld_alarm, ldMtens, ldMones, ldStens, ldSones, ld_num};
    if (rst && (err || ld_time || ld_alarm || ldMtens || ldMones || ldStens || ldSones)) begin
      if (exp_q.size() == 0) chk("unexpected_event", int'(got), 0);
      else chk("load_event", int'(got), int'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    repeat (3) @(negedge clk);
    chk("rst_strobes", int'({ld_time, ld_alarm, ldMtens, ldMones, ldStens, ldSones}), 0);
    chk("rst_num", int'(ld_num), 0);
    chk("rst_run", int'(run), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_rx_ready", int'(rx_ready), 1);
    chk("rst_err", int'(err), 0);
    rst = 1'b1;
    @(negedge clk);

    // T1234: time load with latency checks
    push_load(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
    send_str("T");
    chk("run_time_get", int'(run), 0);
    send_str("1234");
    chk("rx_ready_emit0", int'(rx_ready), 0);
    chk("mtens_latency", int'(ldMtens), 1);
    repeat (3) @(negedge clk);
    chk("sones_latency", int'(ldSones), 1);
    chk("run_emit3", int'(run), 0);
    @(negedge clk);
    chk("idle_after_emit_busy", int'(busy), 0);
    chk("idle_after_emit_run", int'(run), 1);
    chk("idle_after_emit_sones", int'(ldSones), 0);

    // A0559: alarm load, run never drops
    push_load(1'b0, 4'd0, 4'd5, 4'd5, 4'd9);
    send_str("A");
    chk("run_alarm_get", int'(run), 1);
    send_str("0559");
    chk("run_alarm_emit", int'(run), 1);
    repeat (4) @(negedge clk);
    chk("alarm_done_busy", int'(busy), 0);

    // T6: tens digit out of range -> err pulse
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 4'b0000, 4'd0));
    send_str("T6");
    chk("err_pulse", int'(err), 1);
    chk("run_in_err", int'(run), 1);
    @(negedge clk);
    chk("err_one_cycle", int'(err), 0);
    chk("err_back_idle", int'(busy), 0);

    // T12 + ESC: silent abort, then zeros load
    send_str("T12");
    send_byte(8'h1B, w);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_run", int'(run), 1);
    push_load(1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    send_str("T0000");
    repeat (4) @(negedge clk);

    // 'T' held during EMIT is not consumed until IDLE
    push_load(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
    push_load(1'b1, 4'd2, 4'd3, 4'd5, 4'd9);
    send_str("T1234");
    send_byte(8'h54, w);
    chk("emit_hold_waits", w, 4);
    send_str("2359");
    repeat (4) @(negedge clk);

    // Inactivity timeout after "T1"
    exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 4'b0000, 4'd0));
    send_str("T1");
    repeat (14) @(negedge clk);
    chk("timeout_not_early", int'(err), 0);
    @(negedge clk);
    chk("timeout_at_16", int'(err), 1);
    @(negedge clk);

    // Reset asserted during EMIT1
    exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 4'b1000, 4'd4));
    send_str("T4321");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_emit_strobes", int'({ld_time, ld_alarm, ldMtens, ldMones, ldStens, ldSones}), 0);
    chk("rst_emit_run", int'(run), 1);
    chk("rst_emit_busy", int'(busy), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_emit_no_resume", int'(busy), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
